// File: rtl/z_uart_pkg.sv
// Shared types, ASCII constants and the hex-to-ASCII helper for the Z-register UART logger.
// Optional parity state compiled in with Z_UART_PARITY_EN.
`default_nettype none

package z_uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam int         DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef Z_UART_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] v);
    if (v < 4'd10) return ASCII_ZERO + {4'd0, v};
    else           return ASCII_A + {4'd0, v} - 8'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/z_uart_fifo.sv
// 4-bit wide synchronous FIFO; a push while full is accepted only if a pop happens on the same edge.
`default_nettype none

module z_uart_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [3:0]                    wdata,
  output logic [3:0]                    rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/z_uart_logger.sv
// Captures changes of the core's Z result, queues them and sends each as an ASCII hex char over UART.
// Optional even-parity bit compiled in with Z_UART_PARITY_EN.
`default_nettype none

module z_uart_logger
  import z_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  z_in,
  input  logic                        cap_en,
  input  logic                        clr_ovf,
  output logic                        tx,
  output logic                        busy,
  output logic                        ovf,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  state_t      state, state_nx;
  logic [15:0] baud_cnt, baud_nx;
  logic [2:0]  bit_cnt, bit_nx;
  logic [7:0]  shreg, shreg_nx;
  logic [3:0]  last_z;
  logic        primed;
  logic        push, pop, drop;
  logic        full, empty;
  logic [3:0]  rdata;
  logic        baud_done;
`ifdef Z_UART_PARITY_EN
  logic        par, par_nx;
`endif

  assign push      = cap_en && (!primed || (z_in != last_z));
  assign drop      = push && full && !pop;
  assign baud_done = (baud_cnt == 16'(CLK_DIV - 1));

  z_uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (z_in),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_z <= '0;
      primed <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (cap_en) begin
        last_z <= z_in;
        primed <= 1'b1;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
`ifdef Z_UART_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
      busy     <= (state_nx != IDLE);
`ifdef Z_UART_PARITY_EN
      par      <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt + 16'd1;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    pop      = 1'b0;
    tx       = 1'b1;
`ifdef Z_UART_PARITY_EN
    par_nx   = par;
`endif
    case (state)
      IDLE: begin
        baud_nx = '0;
        if (!empty) begin
          pop      = 1'b1;
          shreg_nx = hex_to_ascii(rdata);
          bit_nx   = '0;
          state_nx = START;
`ifdef Z_UART_PARITY_EN
          par_nx   = ^hex_to_ascii(rdata);
`endif
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_done) begin
          baud_nx  = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        tx = shreg[0];
        if (baud_done) begin
          baud_nx  = '0;
          shreg_nx = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef Z_UART_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_nx = bit_cnt + 3'd1;
          end
        end
      end
`ifdef Z_UART_PARITY_EN
      PARITY: begin
        tx = par;
        if (baud_done) begin
          baud_nx  = '0;
          state_nx = STOP;
        end
      end
`endif
      STOP: begin
        tx = 1'b1;
        if (baud_done) begin
          baud_nx  = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        baud_nx  = '0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_z_uart_logger.sv
// Self-checking bench for z_uart_logger: frame-level reference model plus directed table and sequences.
`default_nettype none

module tb_z_uart_logger;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef Z_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] z_in = 4'd0;
  logic       cap_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       tx, busy, ovf;
  logic [2:0] level;

  int total = 0;
  int bad   = 0;
  int dut_frames = 0;

  z_uart_logger #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .z_in(z_in), .cap_en(cap_en), .clr_ovf(clr_ovf),
    .tx(tx), .busy(busy), .ovf(ovf), .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge busy) dut_frames++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending values and a countdown of the frame in flight.
  string    hexs = "0123456789ABCDEF";
  int       mq[$];
  bit [3:0] m_last = 0;
  bit       m_primed = 0;
  int       m_timer = 0;
  bit [7:0] m_byte = 0;
  bit       m_ovf = 0;
  bit       m_pop, m_push, m_drop;
  int       m_pre;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last = 0; m_primed = 0; m_timer = 0; m_ovf = 0;
    end else begin
      m_pre  = mq.size();
      m_pop  = (m_timer == 0) && (m_pre > 0);
      m_push = cap_en && (!m_primed || z_in != m_last);
      if (cap_en) begin m_last = z_in; m_primed = 1; end
      m_drop = m_push && (m_pre == DEPTH) && !m_pop;
      if (m_pop) begin
        m_byte  = hexs[mq.pop_front()];
        m_timer = FRAME;
      end else if (m_timer > 0) begin
        m_timer--;
      end
      if (m_push && !m_drop) mq.push_back(int'(z_in));
      if (m_drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  function automatic int exp_tx();
    int slot;
    if (m_timer == 0) return 1;
    slot = (FRAME - m_timer) / CLK_DIV;
    if (slot == 0) return 0;
    if (slot <= 8) return int'(m_byte[slot-1]);
`ifdef Z_UART_PARITY_EN
    if (slot == 9) return int'(^m_byte);
`endif
    return 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("tx", int'(tx), exp_tx());
      check("busy", int'(busy), int'(m_timer != 0));
      check("level", int'(level), mq.size());
      check("ovf", int'(ovf), int'(m_ovf));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; cap_en = 0; clr_ovf = 0; z_in = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_quiet(input int limit);
    int n = 0;
    while ((busy || level != 0) && n < limit) begin @(negedge clk); n++; end
    if (n >= limit) check("quiet_timeout", n, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_gap();
    int n = 0;
    int gap = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    while (!busy && gap < 10) begin @(negedge clk); gap++; end
    check("idle_gap", gap, 1);
  endtask

  typedef struct {
    bit       cap;
    bit [3:0] z;
    bit       clr;
    int       exp_level;
    bit       exp_ovf;
    bit       exp_busy;
  } vec_t;

  vec_t vt[12];

  initial begin
    int f0, pk, n;

    vt[0]  = '{1, 4'h1, 0, 1, 0, 0};
    vt[1]  = '{1, 4'h2, 0, 1, 0, 1};
    vt[2]  = '{1, 4'h3, 0, 2, 0, 1};
    vt[3]  = '{1, 4'h4, 0, 3, 0, 1};
    vt[4]  = '{1, 4'h5, 0, 4, 0, 1};
    vt[5]  = '{1, 4'h6, 0, 4, 1, 1};
    vt[6]  = '{1, 4'h7, 0, 4, 1, 1};
    vt[7]  = '{0, 4'h7, 1, 4, 0, 1};
    vt[8]  = '{0, 4'h7, 0, 4, 0, 1};
    vt[9]  = '{1, 4'h8, 1, 4, 1, 1};
    vt[10] = '{1, 4'h8, 0, 4, 1, 1};
    vt[11] = '{0, 4'h8, 1, 4, 0, 1};

    do_reset();
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(level), 0);
    check("rst_ovf", int'(ovf), 0);

    // Single value: latency, frame length, no repeat on stable input.
    f0 = dut_frames;
    cap_en = 1; z_in = 4'h3;
    @(negedge clk);
    check("lat_edge1_tx", int'(tx), 1);
    check("lat_edge1_level", int'(level), 1);
    @(negedge clk);
    check("lat_edge2_tx", int'(tx), 0);
    n = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("frame_len", n, FRAME);
    repeat (30) @(negedge clk);
    check("stable_frames", dut_frames - f0, 1);

    // Back-to-back frames.
    f0 = dut_frames; pk = 0;
    z_in = 4'hA; @(negedge clk);
    z_in = 4'hF; @(negedge clk);
    z_in = 4'h0;
    repeat (4) begin @(negedge clk); if (int'(level) > pk) pk = int'(level); end
    check("level_peak", pk, 2);
    check_gap();
    check_gap();
    wait_quiet(400);
    check("b2b_frames", dut_frames - f0, 3);

    // Overflow table.
    do_reset();
    f0 = dut_frames;
    foreach (vt[i]) begin
      cap_en = vt[i].cap; z_in = vt[i].z; clr_ovf = vt[i].clr;
      @(negedge clk);
      check($sformatf("vec%0d_level", i), int'(level), vt[i].exp_level);
      check($sformatf("vec%0d_ovf", i), int'(ovf), int'(vt[i].exp_ovf));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].exp_busy));
    end
    cap_en = 0; clr_ovf = 0;
    wait_quiet(600);
    check("ovf_frames", dut_frames - f0, 5);

    // Reset in the middle of the data bits.
    cap_en = 1; z_in = 4'h7;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    repeat (3 * CLK_DIV) @(negedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_tx", int'(tx), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_level", int'(level), 0);
    @(negedge clk); @(negedge clk);
    f0 = dut_frames;
    rst_n = 1;
    repeat (5) @(negedge clk);
    wait_quiet(200);
    check("postrst_frames", dut_frames - f0, 1);

    // Capture gating.
    f0 = dut_frames;
    cap_en = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      z_in = 4'(i);
    end
    repeat (5) @(negedge clk);
    check("gated_frames", dut_frames - f0, 0);
    z_in = 4'hC; cap_en = 1;
    repeat (3) @(negedge clk);
    wait_quiet(200);
    check("ungated_frames", dut_frames - f0, 1);

    // Randomized traffic with varying change rates.
    for (int blk = 0; blk < 6; blk++) begin
      int rate;
      rate = (blk % 3 == 0) ? 2 : (blk % 3 == 1) ? 40 : 8;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        if ($urandom_range(0, rate - 1) == 0) z_in = 4'($urandom_range(0, 15));
        cap_en  = ($urandom_range(0, 7) != 0);
        clr_ovf = ($urandom_range(0, 31) == 0);
      end
    end
    cap_en = 0; clr_ovf = 0;
    wait_quiet(1000);
    check("final_level", int'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
